regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: ALU writeback and memory (load) writeback.
- Tracks outstanding load destinations in a pending scoreboard and reports read-after-write hazards for rs1/rs2.
- Blocks ALU write-after-write onto a register with an outstanding load.
- Sits between the execute/memory stages and the register file; drives its RegWrite/rd/write_data inputs.

Parameters:
- XLEN, 64, data width of write data
- AW, 5, register index width; register count is 2**AW

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- alu_valid  input  1  ALU writeback request
- alu_ready  output  1  ALU request accepted this cycle (combinational)
- alu_rd  input  AW  ALU destination register
- alu_data  input  XLEN  ALU result
- mem_valid  input  1  load writeback request
- mem_ready  output  1  load request accepted this cycle (combinational)
- mem_rd  input  AW  load destination register
- mem_data  input  XLEN  load data
- rsv_valid  input  1  load issued; reserve rsv_rd
- rsv_rd  input  AW  register to mark pending
- rs1  input  AW  source index 1 for hazard check
- rs2  input  AW  source index 2 for hazard check
- rs1_busy  output  1  rs1 has an outstanding load
- rs2_busy  output  1  rs2 has an outstanding load
- rf_we  output  1  register-file RegWrite
- rf_rd  output  AW  register-file rd
- rf_wdata  output  XLEN  register-file write_data

Behaviour:
- Reset (async, immediate):
  - rf_we=0, rf_rd=0, rf_wdata=0
  - pending[all]=0, source tag=ALU, rr_last=MEM, so the ALU wins the first contest
  - Reset mid-operation discards any staged write and all reservations.
- Transfer occurs when valid&&ready at a posedge; at most one transfer per cycle.
- Eligibility:
  - mem eligible = mem_valid.
  - alu eligible = alu_valid && !(alu_rd!=0 && pending[alu_rd]) (WAW stall).
- Arbitration:
  - One eligible requester: it gets ready.
  - Both eligible: the one not in rr_last gets ready.
  - rr_last updates to the winner on each transfer only.
  - A requester must hold valid and its fields stable until accepted.
- Output stage (1-cycle latency), on a transfer edge:
  - rf_rd <= winner rd, rf_wdata <= winner data, tag <= winner.
  - rf_we <= (winner rd != 0).
- No transfer: rf_we <= 0; rf_rd/rf_wdata hold.
- rf_we is a single-cycle pulse per accepted request.
- The register file commits on the edge following the rf_we cycle.
- Scoreboard:
  - Set: rsv_valid && rsv_rd!=0 sets pending[rsv_rd] on the edge.
  - Clear: on the edge where rf_we=1 and tag=MEM, pending[rf_rd] clears. This is the same edge the register file commits, so busy drops exactly when the data becomes readable.
  - Set and clear of the same index on the same edge: set wins.
  - Reservation of an already-pending index: stays pending (no counting).
  - mem_rd with no matching reservation: written normally, scoreboard unchanged.
- rsN_busy = (rsN != 0) && pending[rsN]; combinational from state only. Index 0 is never busy.
- x0 requests are accepted and consume their grant and round-robin turn, but produce no write.

Test Plan:
- ALU only: alu_valid, rd=5, data=0x1234 → alu_ready same cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=0x1234; following cycle rf_we=0.
- Contention after reset: both valid, alu rd=3, mem rd=4, held 2 cycles → cycle1 ALU granted, cycle2 MEM granted; rf_we pulses rd 3 then rd 4 on consecutive cycles.
- Hazard: rsv rd=7, rs1=7 → rs1_busy=1 next cycle; mem writes rd=7 data=0xAA → rs1_busy=0 on the cycle after rf_we, when the register file returns 0xAA.
- WAW stall: pending[9] set, alu_valid rd=9 → alu_ready=0 until the mem write to 9 commits, then ALU is accepted and rf_we fires for rd=9 with ALU data.
- x0 and same-edge collision: alu rd=0 → alu_ready=1, rf_we stays 0. Mem write to 6 commits on the same edge as rsv rd=6 → pending[6] remains 1.
- Async reset while a write is staged and pending[2]=1 → rf_we=0 and rs busy=0 immediately; after release the ALU wins the first contest.

Source files
------------

// File: rtl/regfile_wb_if.sv
// Writeback bus between the execute/memory stages, the arbiter and the register-file write port.
// The requesters, the load-issue reservation and the hazard query all use this bus.
interface regfile_wb_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned AW   = 5
);
  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            mem_valid;
  logic            mem_ready;
  logic [AW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_data;

  logic            rsv_valid;
  logic [AW-1:0]   rsv_rd;

  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            rs1_busy;
  logic            rs2_busy;

  logic            rf_we;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_wdata;

  // Pipeline side: raises requests and reservations, consumes grants, hazards and the write port.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output rsv_valid, rsv_rd, rs1, rs2,
    input  alu_ready, mem_ready, rs1_busy, rs2_busy,
    input  rf_we, rf_rd, rf_wdata
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  rsv_valid, rsv_rd, rs1, rs2,
    output alu_ready, mem_ready, rs1_busy, rs2_busy,
    output rf_we, rf_rd, rf_wdata
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writeback,
// with a pending-load scoreboard for RAW hazard reporting and ALU WAW stalling.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned AW   = 5
) (
  input logic         clk,
  input logic         reset,
  regfile_wb_if.slave bus
);
  localparam int unsigned NREG = 2 ** AW;

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  src_e            tag;
  src_e            rr_last;
  src_e            win;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;
  logic            rf_we_q;
  logic [AW-1:0]   rf_rd_q;
  logic [XLEN-1:0] rf_wdata_q;

  logic            alu_elig;
  logic            mem_elig;
  logic            grant_alu;
  logic            grant_mem;
  logic            xfer;
  logic [AW-1:0]   win_rd;
  logic [XLEN-1:0] win_data;

  // Eligibility and round-robin grant; an ALU write onto a pending load target must wait.
  always_comb begin
    alu_elig  = bus.alu_valid && !((bus.alu_rd != '0) && pending[bus.alu_rd]);
    mem_elig  = bus.mem_valid;
    grant_mem = mem_elig && (!alu_elig || (rr_last == SRC_ALU));
    grant_alu = alu_elig && !grant_mem;
    xfer      = grant_alu || grant_mem;
    win       = grant_mem ? SRC_MEM : SRC_ALU;
    win_rd    = grant_mem ? bus.mem_rd   : bus.alu_rd;
    win_data  = grant_mem ? bus.mem_data : bus.alu_data;
  end

  // A load clears its entry on the register-file commit edge; a same-edge reservation wins.
  always_comb begin
    pending_nxt = pending;
    if (rf_we_q && (tag == SRC_MEM)) begin
      pending_nxt[rf_rd_q] = 1'b0;
    end
    if (bus.rsv_valid && (bus.rsv_rd != '0)) begin
      pending_nxt[bus.rsv_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      tag        <= SRC_ALU;
      rr_last    <= SRC_MEM;
      pending    <= '0;
    end else begin
      pending <= pending_nxt;
      if (xfer) begin
        rf_we_q    <= (win_rd != '0);
        rf_rd_q    <= win_rd;
        rf_wdata_q <= win_data;
        tag        <= win;
        rr_last    <= win;
      end else begin
        rf_we_q <= 1'b0;
      end
    end
  end

  assign bus.alu_ready = grant_alu;
  assign bus.mem_ready = grant_mem;
  assign bus.rs1_busy  = (bus.rs1 != '0) && pending[bus.rs1];
  assign bus.rs2_busy  = (bus.rs2 != '0) && pending[bus.rs2];
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_rd     = rf_rd_q;
  assign bus.rf_wdata  = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a table of per-cycle vectors plus a hand-written
// async-reset sequence.
module tb_regfile_wb_arbiter;
  localparam int unsigned XLEN = 64;
  localparam int unsigned AW   = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_if #(.XLEN(XLEN), .AW(AW)) bus ();

  regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic            av;
    logic [AW-1:0]   ard;
    logic [XLEN-1:0] ad;
    logic            mv;
    logic [AW-1:0]   mrd;
    logic [XLEN-1:0] md;
    logic            rv;
    logic [AW-1:0]   rrd;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            e_ar;
    logic            e_mr;
    logic            e_b1;
    logic            e_b2;
    logic            e_we;
    logic [AW-1:0]   e_rd;
    logic [XLEN-1:0] e_wd;
  } vec_t;

  vec_t vec [32];
  int   nv     = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] ad,
                     input logic mv, input logic [AW-1:0] mrd, input logic [XLEN-1:0] md,
                     input logic rv, input logic [AW-1:0] rrd,
                     input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                     input logic e_ar, input logic e_mr, input logic e_b1, input logic e_b2,
                     input logic e_we, input logic [AW-1:0] e_rd, input logic [XLEN-1:0] e_wd);
    vec[nv] = '{av, ard, ad, mv, mrd, md, rv, rrd, rs1, rs2,
                e_ar, e_mr, e_b1, e_b2, e_we, e_rd, e_wd};
    nv++;
  endtask

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.alu_valid = v.av;
    bus.alu_rd    = v.ard;
    bus.alu_data  = v.ad;
    bus.mem_valid = v.mv;
    bus.mem_rd    = v.mrd;
    bus.mem_data  = v.md;
    bus.rsv_valid = v.rv;
    bus.rsv_rd    = v.rrd;
    bus.rs1       = v.rs1;
    bus.rs2       = v.rs2;
  endtask

  task automatic set_idle(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    vec_t v;
    v     = '0;
    v.rs1 = rs1;
    v.rs2 = rs2;
    drive(v);
  endtask

  initial begin
    reset = 1'b1;
    set_idle(0, 0);

    //   av ard  adata   mv mrd mdata  rv rrd rs1 rs2 | ar mr b1 b2 we rd wdata
    add(0, 0, 0,         0, 0, 0,      0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0);        // 0 idle
    add(1, 5, 'h1234,    0, 0, 0,      0, 0, 0, 0,      1, 0, 0, 0, 0, 0, 0);        // 1 ALU rd5
    add(0, 0, 0,         0, 0, 0,      0, 0, 0, 0,      0, 0, 0, 0, 1, 5, 'h1234);   // 2 pulse
    add(1, 3, 'h33,      1, 4, 'h44,   0, 0, 0, 0,      0, 1, 0, 0, 0, 5, 'h1234);   // 3 MEM's turn
    add(1, 3, 'h33,      1, 4, 'h45,   0, 0, 0, 0,      1, 0, 0, 0, 1, 4, 'h44);     // 4 ALU's turn
    add(0, 0, 0,         1, 4, 'h45,   0, 0, 0, 0,      0, 1, 0, 0, 1, 3, 'h33);     // 5
    add(0, 0, 0,         0, 0, 0,      0, 0, 0, 0,      0, 0, 0, 0, 1, 4, 'h45);     // 6
    add(0, 0, 0,         0, 0, 0,      1, 7, 7, 0,      0, 0, 0, 0, 0, 4, 'h45);     // 7 reserve 7
    add(0, 0, 0,         0, 0, 0,      0, 0, 7, 0,      0, 0, 1, 0, 0, 4, 'h45);     // 8 rs1 busy
    add(0, 0, 0,         1, 7, 'hAA,   0, 0, 7, 0,      0, 1, 1, 0, 0, 4, 'h45);     // 9 load 7
    add(0, 0, 0,         0, 0, 0,      0, 0, 7, 0,      0, 0, 1, 0, 1, 7, 'hAA);     // 10 commit edge
    add(0, 0, 0,         0, 0, 0,      0, 0, 7, 0,      0, 0, 0, 0, 0, 7, 'hAA);     // 11 readable
    add(0, 0, 0,         0, 0, 0,      1, 9, 0, 9,      0, 0, 0, 0, 0, 7, 'hAA);     // 12 reserve 9
    add(1, 9, 'h99,      0, 0, 0,      0, 0, 0, 9,      0, 0, 0, 1, 0, 7, 'hAA);     // 13 WAW stall
    add(1, 9, 'h99,      1, 9, 'h55,   0, 0, 0, 9,      0, 1, 0, 1, 0, 7, 'hAA);     // 14 load wins
    add(1, 9, 'h99,      0, 0, 0,      0, 0, 0, 9,      0, 0, 0, 1, 1, 9, 'h55);     // 15 still stalled
    add(1, 9, 'h99,      0, 0, 0,      0, 0, 0, 9,      1, 0, 0, 0, 0, 9, 'h55);     // 16 released
    add(0, 0, 0,         0, 0, 0,      0, 0, 0, 0,      0, 0, 0, 0, 1, 9, 'h99);     // 17
    add(1, 0, 'hDEAD,    0, 0, 0,      0, 0, 0, 0,      1, 0, 0, 0, 0, 9, 'h99);     // 18 x0
    add(0, 0, 0,         0, 0, 0,      0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 'hDEAD);   // 19 no we
    add(0, 0, 0,         0, 0, 0,      1, 6, 6, 0,      0, 0, 0, 0, 0, 0, 'hDEAD);   // 20 reserve 6
    add(0, 0, 0,         1, 6, 'h66,   0, 0, 6, 0,      0, 1, 1, 0, 0, 0, 'hDEAD);   // 21 load 6
    add(0, 0, 0,         0, 0, 0,      1, 6, 6, 0,      0, 0, 1, 0, 1, 6, 'h66);     // 22 set+clear
    add(0, 0, 0,         0, 0, 0,      0, 0, 6, 0,      0, 0, 1, 0, 0, 6, 'h66);     // 23 set wins
    add(1, 1, 'h11,      1, 2, 'h22,   0, 0, 6, 0,      1, 0, 1, 0, 0, 6, 'h66);     // 24 ALU's turn
    add(0, 0, 0,         1, 2, 'h22,   0, 0, 6, 0,      0, 1, 1, 0, 1, 1, 'h11);     // 25
    add(0, 0, 0,         0, 0, 0,      0, 0, 6, 0,      0, 0, 1, 0, 1, 2, 'h22);     // 26

    @(negedge clk);
    #1;
    chk("reset rf_we",    XLEN'(bus.rf_we), 0);
    chk("reset rf_rd",    XLEN'(bus.rf_rd), 0);
    chk("reset rf_wdata", bus.rf_wdata, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < nv; i++) begin
      drive(vec[i]);
      #1;
      chk($sformatf("v%0d alu_ready", i), XLEN'(bus.alu_ready), XLEN'(vec[i].e_ar));
      chk($sformatf("v%0d mem_ready", i), XLEN'(bus.mem_ready), XLEN'(vec[i].e_mr));
      chk($sformatf("v%0d rs1_busy", i),  XLEN'(bus.rs1_busy),  XLEN'(vec[i].e_b1));
      chk($sformatf("v%0d rs2_busy", i),  XLEN'(bus.rs2_busy),  XLEN'(vec[i].e_b2));
      chk($sformatf("v%0d rf_we", i),     XLEN'(bus.rf_we),     XLEN'(vec[i].e_we));
      chk($sformatf("v%0d rf_rd", i),     XLEN'(bus.rf_rd),     XLEN'(vec[i].e_rd));
      chk($sformatf("v%0d rf_wdata", i),  bus.rf_wdata,         vec[i].e_wd);
      @(negedge clk);
    end

    // Async reset with a staged write, pending[2] freshly set and pending[6] still set.
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd10;
    bus.alu_data  = 64'hA0;
    bus.rsv_valid = 1'b1;
    bus.rsv_rd    = 5'd2;
    bus.rs1       = 5'd2;
    bus.rs2       = 5'd6;
    #1;
    chk("rst_seq alu_ready", XLEN'(bus.alu_ready), 1);
    @(negedge clk);
    set_idle(2, 6);
    #1;
    chk("rst_seq staged we",  XLEN'(bus.rf_we), 1);
    chk("rst_seq staged rd",  XLEN'(bus.rf_rd), 10);
    chk("rst_seq rs1 busy",   XLEN'(bus.rs1_busy), 1);
    chk("rst_seq rs2 busy",   XLEN'(bus.rs2_busy), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async rst rf_we",    XLEN'(bus.rf_we), 0);
    chk("async rst rf_rd",    XLEN'(bus.rf_rd), 0);
    chk("async rst rf_wdata", bus.rf_wdata, 0);
    chk("async rst rs1 busy", XLEN'(bus.rs1_busy), 0);
    chk("async rst rs2 busy", XLEN'(bus.rs2_busy), 0);
    @(negedge clk);
    reset = 1'b0;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd3;
    bus.alu_data  = 64'h33;
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd4;
    bus.mem_data  = 64'h44;
    #1;
    chk("post-rst alu first", XLEN'(bus.alu_ready), 1);
    chk("post-rst mem wait",  XLEN'(bus.mem_ready), 0);
    @(negedge clk);
    bus.alu_valid = 1'b0;
    #1;
    chk("post-rst mem second", XLEN'(bus.mem_ready), 1);
    chk("post-rst we rd3",     XLEN'(bus.rf_we), 1);
    chk("post-rst rd3",        XLEN'(bus.rf_rd), 3);
    chk("post-rst data3",      bus.rf_wdata, 64'h33);
    @(negedge clk);
    set_idle(0, 0);
    #1;
    chk("post-rst we rd4", XLEN'(bus.rf_we), 1);
    chk("post-rst rd4",    XLEN'(bus.rf_rd), 4);
    chk("post-rst data4",  bus.rf_wdata, 64'h44);
    @(negedge clk);
    #1;
    chk("post-rst we drop", XLEN'(bus.rf_we), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
